aes_round_iter: RTL and testbench
=================================

Name: aes_round_iter

Overview:
- Iterative AES block engine built around one instance of the team's existing combinational `round` module.
- Runs the full AddRoundKey + NR round sequence on one 128-bit block, in either direction.
- Sits between the host data path and the key-schedule store.
- Generalises the single-round datapath with a parametrised round count, encrypt/decrypt sequencing, valid/ready handshakes and a completed-block counter.

Parameters:
- NR, 10, number of rounds (10/12/14 for AES-128/192/256 round counts; keys are supplied externally).
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous active-high reset.
- in_valid_i  input  1  input block valid.
- in_ready_o  output  1  engine can accept a block.
- in_data_i  input  128  input state, row-major packing (bits[127:120]=s(0,0), [119:112]=s(0,1), …, [7:0]=s(3,3)), same as `round`.
- enc_i  input  1  1=encrypt, 0=decrypt; sampled with in_data_i.
- rk_idx_o  output  $clog2(NR+1)  round-key index requested this cycle.
- rk_i  input  128  round key for rk_idx_o, valid in the same cycle (combinational lookup), same packing.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts the result.
- out_data_o  output  128  result state.
- blk_cnt_o  output  CNT_W  number of blocks delivered.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - FSM = IDLE, in_ready_o=1, out_valid_o=0.
  - out_data_o=0, rk_idx_o=0, blk_cnt_o=0.
  - Internal state, mode and round registers = 0.
- FSM states: IDLE, ADDKEY, ROUND, DONE.
- IDLE:
  - in_ready_o=1, rk_idx_o=0.
  - When in_valid_i is high, register in_data_i and enc_i, then go to ADDKEY.
- ADDKEY (1 cycle):
  - rk_idx_o = 0 (enc) or NR (dec).
  - state <= data ^ rk_i.
  - r <= 1; go to ROUND.
- ROUND (NR cycles):
  - rk_idx_o = r (enc) or NR-r (dec).
  - state <= round(state, rk_i, mix_col_i=(r!=NR), enc_or_dec_i=mode).
  - If r==NR go to DONE; otherwise r <= r+1.
- DONE:
  - out_valid_o=1, out_data_o=state; both held stable until out_ready_i is high.
  - On that handshake edge: blk_cnt_o increments (wraps at 2^CNT_W-1 → 0) and the FSM goes to IDLE.
- Handshake rules:
  - in_ready_o is high only in IDLE.
  - in_valid_i in any other state is ignored; the block is not accepted.
- Latency:
  - out_valid_o rises exactly NR+1 clock edges after the accepting edge (11 for NR=10).
  - If out_ready_i is held high, the next block can be accepted one cycle after the output handshake. Throughput is one block per NR+3 cycles.
- Timing of rk_i: it is sampled only in ADDKEY/ROUND. In those states rk_idx_o is registered-state-derived and never combinationally dependent on rk_i.
- Reset mid-operation: the in-flight block is discarded with no output produced, blk_cnt_o is cleared, and the engine returns to IDLE the following cycle.
- out_data_o is updated only when entering DONE. Between blocks it holds the last result.
- Mode is latched at accept; enc_i changes after accept have no effect on the current block.

Test Plan:
- FIPS-197 App. B encrypt: key schedule for 2b7e1516 28aed2a6 abf71588 09cf4f3c, plaintext 3243f6a8 885a308d 313198a2 e0370734 (repacked row-major), enc_i=1, out_ready_i=1.
  - Expect ciphertext 3925841d 02dc09fb dc118597 196a0b32 (row-major).
  - out_valid_o exactly 11 edges after accept; rk_idx_o sequence 0,1,…,10; blk_cnt_o=1.
- Decrypt: same key, input 3925841d…0b32, enc_i=0.
  - Expect 3243f6a8…0734.
  - rk_idx_o sequence 10,9,…,0.
- Backpressure: hold out_ready_i=0 for 5 cycles after out_valid_o rises.
  - out_data_o is stable and in_ready_o=0 throughout; a second in_valid_i pulse in that window is not accepted.
  - Release gives one handshake and blk_cnt_o increments once.
- Back-to-back: 3 blocks with continuous in_valid_i and out_ready_i=1.
  - Accept edges are spaced 13 cycles apart; results are correct; blk_cnt_o=3.
- Reset mid-op: assert rst_i during ROUND with r=5.
  - Next cycle: IDLE, out_valid_o=0, blk_cnt_o=0, in_ready_o=1.
  - A new block afterwards produces the correct result.
- NR=14 instance with an externally supplied FIPS-197 C.3 AES-256 key schedule, input 00112233445566778899aabbccddeeff.
  - Expect 8ea2b7ca516745bfeafc49904b496089.
  - out_valid_o 15 edges after accept.

Source files
------------

// File: rtl/aes_round_iter.sv
// Iterative AES block engine: one combinational round reused NR times,
// with valid/ready on both sides and an external combinational key-schedule lookup.
module aes_round_iter #(
    parameter int NR    = 10,
    parameter int CNT_W = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [127:0]            in_data_i,
    input  logic                    enc_i,
    output logic [$clog2(NR+1)-1:0] rk_idx_o,
    input  logic [127:0]            rk_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [127:0]            out_data_o,
    output logic [CNT_W-1:0]        blk_cnt_o
);
    localparam int RW = $clog2(NR + 1);
    localparam logic [RW-1:0] NR_R = RW'(NR);

    typedef enum logic [1:0] {IDLE, ADDKEY, ROUND, DONE} st_e;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    // Row-major packing: s(r,c) lives in byte lane 15-(4r+c)
    function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
        logic [15:0][7:0] a;
        logic [15:0][7:0] o;
        logic [3:0][7:0]  k;
        a = s;
        o = '0;
        k = inv ? {8'h0e, 8'h0b, 8'h0d, 8'h09} : {8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                for (int j = 0; j < 4; j++)
                    o[15-(4*r+c)] = o[15-(4*r+c)] ^ gf_mul(a[15-(4*((r+j)%4)+c)], k[3-j]);
        return o;
    endfunction

    function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] rk,
                                              input logic mc, input logic en);
        logic [15:0][7:0] a;
        logic [15:0][7:0] b;
        logic [127:0]     bv;
        a = s;
        b = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (en) b[15-(4*r+c)] = sbox(a[15-(4*r+(c+r)%4)]);
                else    b[15-(4*r+(c+r)%4)] = inv_sbox(a[15-(4*r+c)]);
        bv = b;
        if (en) return (mc ? mix_cols(bv, 1'b0) : bv) ^ rk;
        // inverse round keeps the plain key schedule: key is added before InvMixColumns
        return mc ? mix_cols(bv ^ rk, 1'b1) : (bv ^ rk);
    endfunction

    st_e              st_q, st_d;
    logic [127:0]     data_q;
    logic [127:0]     out_q;
    logic [127:0]     rnd;
    logic             mode_q;
    logic [RW-1:0]    r_q;
    logic [CNT_W-1:0] cnt_q;

    assign rnd        = round_fn(data_q, rk_i, r_q != NR_R, mode_q);
    assign out_data_o = out_q;
    assign blk_cnt_o  = cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) st_q <= IDLE;
        else       st_q <= st_d;
    end

    always_comb begin
        st_d        = st_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        rk_idx_o    = '0;
        case (st_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) st_d = ADDKEY;
            end
            ADDKEY: begin
                rk_idx_o = mode_q ? '0 : NR_R;
                st_d     = ROUND;
            end
            ROUND: begin
                rk_idx_o = mode_q ? r_q : NR_R - r_q;
                if (r_q == NR_R) st_d = DONE;
            end
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) st_d = IDLE;
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
            out_q  <= '0;
            mode_q <= 1'b0;
            r_q    <= '0;
            cnt_q  <= '0;
        end else begin
            case (st_q)
                IDLE: if (in_valid_i) begin
                    data_q <= in_data_i;
                    mode_q <= enc_i;
                end
                ADDKEY: begin
                    data_q <= data_q ^ rk_i;
                    r_q    <= RW'(1);
                end
                ROUND: begin
                    data_q <= rnd;
                    if (r_q == NR_R) out_q <= rnd;
                    else             r_q   <= r_q + 1'b1;
                end
                DONE: if (out_ready_i) cnt_q <= cnt_q + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_round_iter.sv
// Scoreboard bench for aes_round_iter: NR=10 and NR=14 instances, byte-array AES
// reference model, FIPS-197 known answers plus random blocks.
module tb_aes_round_iter;
    localparam logic [127:0] KEY128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT128  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT128  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT256  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid, in_ready, enc, out_valid, out_ready;
    logic [127:0] in_data, rk, out_data;
    logic [3:0]   rk_idx;
    logic [15:0]  blk_cnt;
    logic         v14, rdy14, enc14, ov14, ordy14;
    logic [127:0] d14, rk14, od14;
    logic [3:0]   idx14;
    logic [15:0]  cnt14;

    logic [7:0]   sb[256];
    logic [7:0]   isb[256];
    logic [127:0] ks10[0:10];
    logic [127:0] ks14[0:14];
    logic [127:0] rk10r[16];
    logic [127:0] rk14r[16];
    logic [127:0] exp_q[$];
    logic [127:0] exp14_q[$];
    int           acc_log[$];
    int           errors = 0, checks = 0, cyc = 0;

    aes_round_iter #(.NR(10)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .enc_i(enc), .rk_idx_o(rk_idx), .rk_i(rk),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .blk_cnt_o(blk_cnt)
    );

    aes_round_iter #(.NR(14)) dut14 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(v14), .in_ready_o(rdy14),
        .in_data_i(d14), .enc_i(enc14), .rk_idx_o(idx14), .rk_i(rk14),
        .out_valid_o(ov14), .out_ready_i(ordy14), .out_data_o(od14),
        .blk_cnt_o(cnt14)
    );

    assign rk   = rk10r[rk_idx];
    assign rk14 = rk14r[idx14];

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] x, input int k);
        return (x << k) | (x >> (8 - k));
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // FIPS byte order (byte i = s(i%4, i/4)) <-> row-major; a transpose, so self-inverse
    function automatic logic [127:0] tr(input logic [127:0] x);
        logic [127:0] y;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                y[127-8*(4*r+c) -: 8] = x[127-8*(r+4*c) -: 8];
        return y;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    function automatic logic [127:0] rkey(input int nr, input int j);
        return (nr == 14) ? ks14[j] : ks10[j];
    endfunction

    task automatic expand(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] w[60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) t = subw(t);
            w[i] = w[i-nk] ^ t;
        end
        for (int j = 0; j <= nr; j++)
            if (nr == 14) ks14[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
            else          ks10[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    endtask

    // Cipher / inverse cipher on a FIPS-ordered block using the tables above
    function automatic logic [127:0] ref_aes(input logic [127:0] blk, input int nr, input bit en);
        logic [7:0]   s[16], t[16], a[4], m[4];
        logic [127:0] k, o;
        m = en ? '{8'h02, 8'h03, 8'h01, 8'h01} : '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8];
        k = rkey(nr, en ? 0 : nr);
        for (int i = 0; i < 16; i++) s[i] ^= k[127-8*i -: 8];
        for (int rd = 1; rd <= nr; rd++) begin
            if (en) begin
                for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) s[r+4*c] = t[r+4*((c+r)%4)];
            end else begin
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) t[r+4*((c+r)%4)] = s[r+4*c];
                for (int i = 0; i < 16; i++) s[i] = isb[t[i]];
            end
            for (int pass = 0; pass < 2; pass++) begin
                if (pass == (en ? 1 : 0)) begin
                    k = rkey(nr, en ? rd : nr - rd);
                    for (int i = 0; i < 16; i++) s[i] ^= k[127-8*i -: 8];
                end else if (rd < nr) begin
                    for (int c = 0; c < 4; c++) begin
                        for (int j = 0; j < 4; j++) a[j] = s[4*c+j];
                        for (int r = 0; r < 4; r++)
                            s[4*c+r] = gm(a[r], m[0]) ^ gm(a[(r+1)%4], m[1]) ^
                                       gm(a[(r+2)%4], m[2]) ^ gm(a[(r+3)%4], m[3]);
                    end
                end
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    task automatic init_tables();
        logic [7:0] p, q;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q ^= q << 1;
            q ^= q << 2;
            q ^= q << 4;
            if (q[7]) q ^= 8'h09;
            sb[p] = q ^ rotl(q, 1) ^ rotl(q, 2) ^ rotl(q, 3) ^ rotl(q, 4) ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
        expand({KEY128, 128'h0}, 4, 10);
        expand(KEY256, 8, 14);
        for (int j = 0; j < 16; j++) begin
            rk10r[j] = (j <= 10) ? tr(ks10[j]) : '0;
            rk14r[j] = (j <= 14) ? tr(ks14[j]) : '0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // NR=10 monitor: rk index sequence, output latency, scoreboard compare
    initial begin : mon10
        int  a_edge;
        bit  act, a_enc, pv;
        act = 0; pv = 0; a_edge = 0; a_enc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                act = 0;
                pv  = 0;
            end else begin
                if (act && cyc >= a_edge && cyc <= a_edge + 10)
                    chk("rk_idx", 128'(rk_idx), 128'(a_enc ? cyc - a_edge : 10 - (cyc - a_edge)));
                if (out_valid && !pv) begin
                    chk("latency10", 128'(cyc - a_edge), 128'(11));
                    act = 0;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) fail("unexpected output (NR=10)");
                    else chk("data10", out_data, exp_q.pop_front());
                end
                if (in_valid && in_ready) begin
                    act    = 1;
                    a_edge = cyc + 1;
                    a_enc  = enc;
                    acc_log.push_back(cyc + 1);
                end
                pv = out_valid;
            end
        end
    end

    initial begin : mon14
        int a14;
        bit pv14;
        a14 = 0; pv14 = 0;
        forever begin
            @(negedge clk);
            if (rst) pv14 = 0;
            else begin
                if (ov14 && !pv14) chk("latency14", 128'(cyc - a14), 128'(15));
                if (ov14 && ordy14) begin
                    if (exp14_q.size() == 0) fail("unexpected output (NR=14)");
                    else chk("data14", od14, exp14_q.pop_front());
                end
                if (v14 && rdy14) a14 = cyc + 1;
                pv14 = ov14;
            end
        end
    end

    task automatic send(input bit big, input logic [127:0] d, input bit en, input logic [127:0] e);
        int n;
        n = 0;
        if (big) begin v14 = 1; d14 = d; enc14 = en; exp14_q.push_back(e); end
        else begin in_valid = 1; in_data = d; enc = en; exp_q.push_back(e); end
        do begin
            @(negedge clk);
            n++;
        end while (!(big ? rdy14 : in_ready) && n < 300);
        if (n >= 300) fail("accept timeout");
        @(posedge clk);
        #1;
        // scramble inputs after accept: mode and data must already be latched
        if (big) begin v14 = 0; enc14 = ~en; d14 = rnd128(); end
        else begin in_valid = 0; enc = ~en; in_data = rnd128(); end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp14_q.size() != 0) && n < 600) begin
            @(posedge clk);
            n++;
        end
        if (n >= 600) fail("drain timeout");
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] b;
        bit           e, stop;
        int           n, n0;
        rst = 1; in_valid = 0; in_data = '0; enc = 0; out_ready = 1;
        v14 = 0; d14 = '0; enc14 = 0; ordy14 = 1;
        init_tables();
        repeat (2) @(posedge clk);
        #1;
        chk("rst in_ready", 128'(in_ready), 128'(1));
        chk("rst out_valid", 128'(out_valid), 128'(0));
        chk("rst out_data", out_data, '0);
        chk("rst rk_idx", 128'(rk_idx), 128'(0));
        chk("rst blk_cnt", 128'(blk_cnt), 128'(0));
        chk("rst in_ready14", 128'(rdy14), 128'(1));
        rst = 0;

        send(0, tr(PT128), 1, tr(CT128));
        drain();
        chk("blk_cnt kat enc", 128'(blk_cnt), 128'(1));
        send(0, tr(CT128), 0, tr(PT128));
        drain();
        chk("blk_cnt kat dec", 128'(blk_cnt), 128'(2));

        out_ready = 0;
        send(0, tr(PT128), 1, tr(CT128));
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) fail("out_valid timeout");
        n0 = acc_log.size();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            in_valid = (k == 1);
            in_data  = rnd128();
            chk("bp out_valid", 128'(out_valid), 128'(1));
            chk("bp in_ready", 128'(in_ready), 128'(0));
            chk("bp out_data", out_data, tr(CT128));
        end
        in_valid  = 0;
        out_ready = 1;
        drain();
        repeat (20) @(posedge clk);
        #1;
        chk("bp no accept", 128'(acc_log.size()), 128'(n0));
        chk("blk_cnt bp", 128'(blk_cnt), 128'(3));

        for (int i = 0; i < 3; i++) begin
            b = rnd128();
            e = 1'($urandom_range(0, 1));
            send(0, tr(b), e, tr(ref_aes(b, 10, e)));
        end
        drain();
        n = acc_log.size();
        chk("b2b spacing a", 128'(acc_log[n-2] - acc_log[n-3]), 128'(13));
        chk("b2b spacing b", 128'(acc_log[n-1] - acc_log[n-2]), 128'(13));
        chk("blk_cnt b2b", 128'(blk_cnt), 128'(6));

        stop = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    b = rnd128();
                    e = 1'($urandom_range(0, 1));
                    send(0, tr(b), e, tr(ref_aes(b, 10, e)));
                end
                drain();
                stop = 1;
            end
            begin
                while (!stop) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("blk_cnt random", 128'(blk_cnt), 128'(14));

        b = rnd128();
        send(0, tr(b), 1, tr(ref_aes(b, 10, 1)));
        repeat (5) @(posedge clk);
        #1;
        chk("mid rk_idx r=5", 128'(rk_idx), 128'(5));
        rst = 1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 0;
        chk("mid rst in_ready", 128'(in_ready), 128'(1));
        chk("mid rst out_valid", 128'(out_valid), 128'(0));
        chk("mid rst blk_cnt", 128'(blk_cnt), 128'(0));
        chk("mid rst rk_idx", 128'(rk_idx), 128'(0));
        b = rnd128();
        send(0, tr(b), 0, tr(ref_aes(b, 10, 0)));
        drain();
        chk("blk_cnt after rst", 128'(blk_cnt), 128'(1));

        send(1, tr(PT256), 1, tr(CT256));
        drain();
        b = rnd128();
        send(1, tr(b), 0, tr(ref_aes(b, 14, 0)));
        drain();
        chk("blk_cnt14", 128'(cnt14), 128'(2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
